// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences data-memory loads/stores over a req/ready
// handshake, stalls the PC while an access is outstanding, gates load
// write-back, flags misaligned accesses and traps hung memory as a fault.
module mem_access_seq #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  input  logic       i_dmem_ready,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_PCEnable,
  output logic       o_regWriteLoad,
  output logic       o_misaligned,
  output logic       o_fault,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Counter value on the last WAIT cycle before giving up on the memory.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             isStore_q, isStore_d;

  logic isLoadOp, isStoreOp, isMemOp, misaligned;

  // Opcode low bits and the signed/unsigned funct3 bit play no part in
  // sequencing; they are gathered here only so they are visibly consumed.
  logic unusedBits;
  assign unusedBits = ^{i_opcode[1:0], i_funct3[2]};

  // Decode the instruction class and the alignment of the requested access.
  always_comb begin
    isLoadOp  = (i_opcode[6:2] == 5'b00000);
    isStoreOp = (i_opcode[6:2] == 5'b01000);
    isMemOp   = isLoadOp | isStoreOp;
    case (i_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_addr_lo[0];
      2'b10:   misaligned = (i_addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Next-state logic: start accesses from IDLE, count stalled WAIT cycles,
  // and park in FAULT once the memory has been silent for too long.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isStore_d = isStore_q;
    case (state_q)
      S_IDLE: begin
        if (isMemOp && !misaligned) begin
          isStore_d = isStoreOp;
          cnt_d     = '0;
          state_d   = i_dmem_ready ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_dmem_ready) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_FAULT;
    endcase
  end

  // State, wait counter and latched access direction; reset abandons any
  // access in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      isStore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isStore_q <= isStore_d;
    end
  end

  // Outputs follow state and live inputs; everything is held low in reset.
  always_comb begin
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_PCEnable     = 1'b0;
    o_regWriteLoad = 1'b0;
    o_misaligned   = 1'b0;
    o_fault        = 1'b0;
    o_busy         = 1'b0;
    if (!i_rst) begin
      case (state_q)
        S_IDLE: begin
          if (!isMemOp) begin
            o_PCEnable     = 1'b1;
            o_regWriteLoad = 1'b1;
          end else if (misaligned) begin
            o_misaligned = 1'b1;
            o_PCEnable   = 1'b1;
          end else begin
            o_dmem_req = 1'b1;
            o_dmem_we  = isStoreOp;
          end
        end
        S_WAIT: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = isStore_q;
          o_busy     = 1'b1;
        end
        S_DONE: begin
          o_PCEnable     = 1'b1;
          o_regWriteLoad = !isStore_q;
          o_busy         = 1'b1;
        end
        default: begin
          o_fault = 1'b1;
          o_busy  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed vectors for mem_access_seq, checked every
// cycle against a transaction-level model plus hand-computed literals.
module tb_mem_access_seq;

  localparam int TIMEOUT = 15;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [1:0] addrLo = 2'd0;
  logic       ready = 1'b0;

  logic dmemReq, dmemWe, pcEnable, regWriteLoad, misalignedO, faultO, busyO;

  mem_access_seq #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_opcode       (opcode),
    .i_funct3       (funct3),
    .i_addr_lo      (addrLo),
    .i_dmem_ready   (ready),
    .o_dmem_req     (dmemReq),
    .o_dmem_we      (dmemWe),
    .o_PCEnable     (pcEnable),
    .o_regWriteLoad (regWriteLoad),
    .o_misaligned   (misalignedO),
    .o_fault        (faultO),
    .o_busy         (busyO)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int reqCount = 0;
  int misCount = 0;
  logic [6:0] lastOut;

  // Transaction-level model: an outstanding access, how long it has waited,
  // a completion pending, or a trapped fault.
  bit mActive = 0;
  bit mStore = 0;
  bit mDone = 0;
  bit mFault = 0;
  int mWaits = 0;

  function automatic bit isLoad(logic [6:0] op);
    return op[6:2] == 5'b00000;
  endfunction

  function automatic bit isStore(logic [6:0] op);
    return op[6:2] == 5'b01000;
  endfunction

  // An access is misaligned if its byte size does not divide the address.
  function automatic bit misRule(logic [2:0] f3, logic [1:0] a);
    int size;
    if (f3[1:0] == 2'b11) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(a) % size) != 0;
  endfunction

  function automatic logic [6:0] dutOut();
    return {dmemReq, dmemWe, pcEnable, regWriteLoad, misalignedO, faultO, busyO};
  endfunction

  // Expected {req, we, pcEnable, regWriteLoad, misaligned, fault, busy}.
  function automatic logic [6:0] modelOut();
    bit mem;
    if (rst) return 7'b0;
    if (mFault) return 7'b0000011;
    if (mDone) return {4'b0010 | {3'b000, !mStore}, 3'b001};
    if (mActive) return {1'b1, mStore, 4'b0000, 1'b1};
    mem = isLoad(opcode) || isStore(opcode);
    if (!mem) return 7'b0011000;
    if (misRule(funct3, addrLo)) return 7'b0010100;
    return {1'b1, isStore(opcode), 5'b00000};
  endfunction

  function automatic void modelUpdate();
    if (rst) begin
      mActive = 0; mStore = 0; mDone = 0; mFault = 0; mWaits = 0;
    end else if (mFault) begin
      mFault = 1;
    end else if (mDone) begin
      mDone = 0;
    end else if (mActive) begin
      if (ready) begin
        mActive = 0;
        mDone = 1;
      end else begin
        mWaits++;
        if (TIMEOUT != 0 && mWaits == TIMEOUT) begin
          mActive = 0;
          mFault = 1;
        end
      end
    end else if ((isLoad(opcode) || isStore(opcode)) && !misRule(funct3, addrLo)) begin
      mStore = isStore(opcode);
      if (ready) mDone = 1;
      else begin
        mActive = 1;
        mWaits = 0;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got {req,we,pc,rwl,mis,flt,busy}=%b want %b",
               name, cycle, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the
  // model, and return just after the rising edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [1:0] a, input logic rdy);
    opcode = op;
    funct3 = f3;
    addrLo = a;
    ready  = rdy;
    @(negedge clk);
    cycle++;
    lastOut = dutOut();
    checkOutput("model", lastOut, modelOut());
    if (dmemReq) reqCount++;
    if (misalignedO) misCount++;
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    applyStimulus(OP_LOAD, 3'b010, 2'b00, 1'b1);
    checkOutput("reset outputs", lastOut, 7'b0000000);
    rst = 1'b0;

    // Non-memory instruction held three cycles, ready noise ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_RTYPE, 3'b000, 2'b00, i == 1);
      checkOutput("rtype literal", lastOut, 7'b0011000);
    end

    // Zero-wait word load.
    reqCount = 0;
    applyStimulus(OP_LOAD, 3'b010, 2'b00, 1'b1);
    checkOutput("load c0 literal", lastOut, 7'b1000000);
    applyStimulus(OP_ITYPE, 3'b000, 2'b00, 1'b1);
    checkOutput("load done literal", lastOut, 7'b0011001);
    applyStimulus(OP_ITYPE, 3'b000, 2'b00, 1'b0);
    checkOutput("load back idle", lastOut, 7'b0011000);
    checkValue("load req cycles", reqCount, 1);

    // Half store with three wait cycles; inputs scrambled during WAIT.
    reqCount = 0;
    applyStimulus(OP_STORE, 3'b001, 2'b10, 1'b0);
    applyStimulus(OP_RTYPE, 3'b011, 2'b01, 1'b0);
    applyStimulus(OP_LOAD,  3'b010, 2'b11, 1'b0);
    applyStimulus(OP_ITYPE, 3'b000, 2'b00, 1'b1);
    checkOutput("store wait literal", lastOut, 7'b1100001);
    applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b1);
    checkOutput("store done literal", lastOut, 7'b0010001);
    checkValue("store req cycles", reqCount, 4);

    // Misalignment table: word@01, half@01, illegal size, byte@11 (aligned).
    reqCount = 0;
    misCount = 0;
    applyStimulus(OP_LOAD, 3'b010, 2'b01, 1'b0);
    checkOutput("misaligned literal", lastOut, 7'b0010100);
    applyStimulus(OP_STORE, 3'b001, 2'b01, 1'b1);
    applyStimulus(OP_STORE, 3'b011, 2'b00, 1'b1);
    applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b0);
    checkValue("misaligned pulses", misCount, 3);
    checkValue("misaligned no req", reqCount, 0);
    applyStimulus(OP_LOAD, 3'b100, 2'b11, 1'b0);
    applyStimulus(OP_ITYPE, 3'b000, 2'b00, 1'b1);
    applyStimulus(OP_ITYPE, 3'b000, 2'b00, 1'b0);

    // Hung memory: request for 1 + TIMEOUT cycles, then sticky fault.
    reqCount = 0;
    for (int i = 0; i < TIMEOUT + 3; i++) applyStimulus(OP_LOAD, 3'b010, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b1);
    checkValue("timeout req cycles", reqCount, 16);
    checkOutput("fault literal", lastOut, 7'b0000011);
    rst = 1'b1;
    applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b0);
    rst = 1'b0;
    applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b0);
    checkOutput("fault cleared", lastOut, 7'b0011000);

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(OP_STORE, 3'b000, 2'b00, 1'b0);
    applyStimulus(OP_STORE, 3'b000, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset literal", dutOut(), 7'b0000000);
    modelUpdate();
    applyStimulus(OP_STORE, 3'b000, 2'b00, 1'b1);
    rst = 1'b0;
    applyStimulus(OP_RTYPE, 3'b000, 2'b00, 1'b1);
    checkOutput("after reset idle", lastOut, 7'b0011000);

    // Fresh timeout after reset confirms the wait count starts from zero.
    reqCount = 0;
    for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus(OP_LOAD, 3'b000, 2'b00, 1'b0);
    checkValue("second timeout req cycles", reqCount, 16);
    checkOutput("second fault literal", lastOut, 7'b0000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequences data-memory accesses for the core so that loads and stores may take a variable number of cycles.
- Sits between the instruction decoder and the data-memory port.
- Decodes the opcode, issues a request/ready handshake to memory, and stalls the PC until the access completes.
- Gates load write-back, flags misaligned accesses, and traps hung memory with a timeout fault.

Parameters:
- TIMEOUT, 15: maximum number of cycles spent in WAIT before FAULT; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_opcode  in  7  current instruction opcode. Load = opcode[6:2]==5'b00000; store = opcode[6:2]==5'b01000.
- i_funct3  in  3  access size: [1:0]=00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- i_addr_lo  in  2  effective address bits [1:0].
- i_dmem_ready  in  1  memory completes the access this cycle.
- o_dmem_req  out  1  memory request valid.
- o_dmem_we  out  1  write strobe; valid only with o_dmem_req.
- o_PCEnable  out  1  PC may advance this cycle.
- o_regWriteLoad  out  1  register-file write permitted this cycle.
- o_misaligned  out  1  one-cycle pulse for a misaligned access.
- o_fault  out  1  sticky timeout fault.
- o_busy  out  1  state != IDLE.

Behaviour:
- Clocking: state, counter, latched type and fault flag update on the rising edge of i_clk. All outputs are combinational from state and inputs.
- Reset:
  - While i_rst=1: state=IDLE, counter=0, fault=0, latched is_store=0.
  - During reset all outputs are forced to 0.
  - Reset asserted mid-access abandons the access immediately; no completion is generated.
- Misaligned rule:
  - Half access with addr_lo[0]=1.
  - Word access with addr_lo!=0.
  - Any access with funct3[1:0]=11.
  - Byte accesses are never misaligned.
- States: IDLE, WAIT, DONE, FAULT (2-bit encoding).
- IDLE, opcode neither load nor store:
  - o_PCEnable=1, o_regWriteLoad=1, o_dmem_req=0.
  - Stay in IDLE.
- IDLE, load or store, misaligned:
  - o_misaligned=1, o_PCEnable=1, o_regWriteLoad=0, o_dmem_req=0.
  - Stay in IDLE. Trap handling is done elsewhere.
- IDLE, load or store, aligned:
  - o_dmem_req=1, o_dmem_we=is store, o_PCEnable=0, o_regWriteLoad=0.
  - Latch is_store and clear the counter.
  - Next state is DONE if i_dmem_ready=1, else WAIT.
- WAIT:
  - o_dmem_req=1, o_dmem_we=latched is_store, o_PCEnable=0, o_regWriteLoad=0.
  - The counter increments each cycle that ready=0.
  - If ready=1, go to DONE; ready takes priority over timeout in the same cycle.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1, go to FAULT.
  - i_opcode, i_funct3 and i_addr_lo are ignored while in WAIT.
- DONE:
  - o_dmem_req=0, o_PCEnable=1, o_regWriteLoad=!latched is_store.
  - Always go to IDLE.
- FAULT:
  - o_fault=1, o_busy=1, all other outputs 0.
  - Exit only by reset.
- Latency:
  - Load with zero-wait memory takes 2 cycles (IDLE, DONE).
  - A load or store with N wait cycles takes N+2 cycles.
  - Non-memory instructions take 1 cycle.
- Other rules:
  - i_dmem_ready seen while no request is outstanding (IDLE with a non-memory opcode, DONE, or FAULT) is ignored.
  - Back-to-back memory instructions always pass through IDLE between accesses, so each access gets a fresh request.

Test Plan:
- Reset, then opcode 0110011 (R-type) held for 3 cycles -> o_PCEnable=1 and o_regWriteLoad=1 every cycle; o_dmem_req=0; o_busy=0.
- Load 0000011, funct3=010, addr_lo=00, ready=1 immediately -> cycle 0: req=1, we=0, PCEnable=0. Cycle 1 (DONE): PCEnable=1, regWriteLoad=1. Back in IDLE at cycle 2.
- Store 0100011, funct3=001, addr_lo=10, ready after 3 wait cycles -> req=1 and we=1 for 4 cycles; PCEnable=1 with regWriteLoad=0 in DONE. Toggling the opcode during WAIT has no effect.
- Load funct3=010, addr_lo=01 -> o_misaligned=1 for one cycle, PCEnable=1, regWriteLoad=0, req never asserts; state stays IDLE.
- TIMEOUT=15, load with ready held 0 -> req high for 16 cycles (1 IDLE + 15 WAIT), then o_fault=1, o_busy=1, PCEnable=0. Fault persists until i_rst pulses.
- i_rst asserted asynchronously mid-WAIT -> all outputs 0 immediately; after release, state is IDLE with counter=0.
